div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the DIV/DIVU path of the execute stage.
- Accepts a divide request from E, runs a radix-2 restoring divider for DATA_W iterations, and holds the pipeline stalled while it works.
- Delivers {HI=remainder, LO=quotient} with a one-cycle HILO write strobe.
- Sits between the decoded aluop/write_hilo controls and the HILO register, under control of the hazard unit.

Parameters:
- DATA_W, 32: operand width. The counter width is clog2(DATA_W)+1.
- ZERO_QUOT, 32'hFFFF_FFFF: LO value returned on divide-by-zero.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  E-stage instruction is DIV/DIVU. Held high by the pipeline while stalled.
- signed_i  in  1  1=DIV (signed), 0=DIVU. Sampled with start_i in IDLE.
- a_i  in  DATA_W  dividend (rs). Sampled in IDLE.
- b_i  in  DATA_W  divisor (rt). Sampled in IDLE.
- annul_i  in  1  flush/exception. Aborts any operation in progress.
- stall_o  out  1  request to hold F/D/E.
- ready_o  out  1  result valid, one-cycle pulse.
- hilo_we_o  out  1  HILO write enable, equal to ready_o.
- result_o  out  2*DATA_W  {HI=remainder, LO=quotient}. Valid only while ready_o=1, else 0.

Behaviour:
- Reset: state=IDLE, counter=0, all registers 0; stall_o=0, ready_o=0, hilo_we_o=0, result_o=0. rst has priority over every input.
- States: IDLE, ZERO, RUN, DONE.
- IDLE:
  - start_i=1 & annul_i=0 & b_i==0 -> ZERO.
  - start_i=1 & annul_i=0 & b_i!=0 -> RUN. On this transition:
    - latch |a| and |b| (absolute values only when signed_i=1);
    - latch neg_q = signed_i & (a[MSB]^b[MSB]) and neg_r = signed_i & a[MSB];
    - latch raw a_i; clear the partial remainder; counter=0.
- RUN:
  - One iteration per cycle: shift {rem,quo} left 1; trial = rem - |b| (DATA_W+1 bits).
  - If trial is non-negative, rem=trial and quo LSB=1; else quo LSB=0.
  - counter increments each cycle. After iteration DATA_W (counter==DATA_W-1 on the last iteration) -> DONE.
- ZERO: one cycle -> DONE. Result = {a_i latched, ZERO_QUOT}. No sign fix-up.
- DONE:
  - ready_o=1 and hilo_we_o=1 for exactly this cycle. Next state is IDLE unconditionally.
  - LO = neg_q ? -quo : quo. HI = neg_r ? -rem : rem. Arithmetic is two's complement, truncated to DATA_W.
  - 0x80000000 / -1 (signed) yields LO=0x80000000, HI=0, with no trap.
- stall_o = start_i & (state != DONE). This is combinational, so the stall is asserted in the request cycle itself.
- Latency with b!=0: request seen in cycle 0 (IDLE), RUN in cycles 1..DATA_W, DONE in cycle DATA_W+1. stall_o is high for DATA_W+1 cycles; the pipeline advances on the DONE edge.
- Latency with b==0: IDLE (cycle 0), ZERO (cycle 1), DONE (cycle 2).
- annul_i=1 in any state:
  - next state IDLE, counter cleared;
  - ready_o and hilo_we_o forced to 0 in that cycle, even in DONE;
  - stall_o forced to 0 in that cycle.
- Back-to-back divides: if start_i is high in the IDLE cycle after DONE, it is a new instruction and starts a new operation. No dead cycle is required beyond the IDLE cycle.
- start_i dropping mid-RUN (not expected) is ignored. The operation completes and pulses ready_o.
- Operand changes after the IDLE sample have no effect.

Test Plan:
1. DIVU 100/7: start_i=1 held.
   - Required: stall_o high for cycles 0..32.
   - Required: cycle 33 ready_o=hilo_we_o=1, result_o={32'd2, 32'd14}.
   - Required: cycle 34 IDLE.
2. DIV -7/2 (a=0xFFFFFFF9, b=2).
   - Required: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
3. DIV 0x80000000/0xFFFFFFFF.
   - Required: LO=0x80000000, HI=0.
   - DIVU of the same operands: LO=0, HI=0x80000000.
4. DIV 5/0.
   - Required: ZERO at cycle 1, ready_o at cycle 2, result_o={32'd5, 32'hFFFFFFFF}; stall_o 0 in cycle 2.
5. annul_i pulsed at RUN cycle 10 of 100/7.
   - Required: IDLE next cycle; no ready_o or hilo_we_o ever for that op.
   - Then issue 9/3: required {0, 3} at cycle 33 after restart.
   - Repeat with rst=1 mid-RUN: required all outputs 0 and IDLE.
6. Back-to-back DIVU 50/5 then DIVU 7/9.
   - Required: first ready {0, 10}, second op starts the cycle after DONE.
   - Required: second ready 34 cycles later with {7, 0}; exactly two hilo_we_o pulses.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for DIV/DIVU in the execute stage.
// Runs a radix-2 restoring divider over DATA_W cycles while stalling F/D/E,
// then presents {HI=remainder, LO=quotient} for one cycle with a HILO write.
module div_seq_ctrl #(
   parameter int unsigned       DATA_W    = 32,
   parameter logic [DATA_W-1:0] ZERO_QUOT = {DATA_W{1'b1}}
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start_i,
   input  logic                  signed_i,
   input  logic [DATA_W-1:0]     a_i,
   input  logic [DATA_W-1:0]     b_i,
   input  logic                  annul_i,
   output logic                  stall_o,
   output logic                  ready_o,
   output logic                  hilo_we_o,
   output logic [2*DATA_W-1:0]   result_o
);

   localparam int unsigned CNT_W = $clog2(DATA_W) + 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ZERO = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t                state_r;
   state_t                state_s;
   logic [CNT_W-1:0]      cnt_r;
   logic [DATA_W-1:0]     rem_r;
   logic [DATA_W-1:0]     quo_r;
   logic [DATA_W-1:0]     divisor_r;
   logic                  neg_q_r;
   logic                  neg_r_r;

   logic [DATA_W:0]       shifted_s;
   logic [DATA_W:0]       trial_s;
   logic                  last_iter_s;
   logic                  stall_s;
   logic                  ready_s;
   logic [2*DATA_W-1:0]   result_s;

   // Magnitude of an operand; only signed operations take the absolute value.
   function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] x, input logic sgn);
      if (sgn && x[DATA_W-1]) begin
         mag = -x;
      end else begin
         mag = x;
      end
   endfunction

   // Two's-complement negation applied conditionally (sign fix-up on results).
   function automatic logic [DATA_W-1:0] neg_if(input logic [DATA_W-1:0] x, input logic n);
      if (n) begin
         neg_if = -x;
      end else begin
         neg_if = x;
      end
   endfunction

   // The remainder MSB can only be set when the trial subtraction is certain to
   // succeed, so the restore path never loses it when dropping to DATA_W bits.
   assign shifted_s   = {rem_r, quo_r[DATA_W-1]};
   assign trial_s     = shifted_s - {1'b0, divisor_r};
   assign last_iter_s = (cnt_r == CNT_W'(DATA_W - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state logic; annul returns to IDLE from anywhere.
   always_comb begin
      state_s = state_r;
      if (annul_i) begin
         state_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  if (b_i == '0) begin
                     state_s = ST_ZERO;
                  end else begin
                     state_s = ST_RUN;
                  end
               end else begin
                  state_s = ST_IDLE;
               end
            end
            ST_ZERO: state_s = ST_DONE;
            ST_RUN: begin
               if (last_iter_s) begin
                  state_s = ST_DONE;
               end else begin
                  state_s = ST_RUN;
               end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
         endcase
      end
   end

   // Operand capture and one restoring-division iteration per RUN cycle.
   // Divide-by-zero preloads rem/quo with the final result and no sign fix-up.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= '0;
         rem_r     <= '0;
         quo_r     <= '0;
         divisor_r <= '0;
         neg_q_r   <= 1'b0;
         neg_r_r   <= 1'b0;
      end else if (annul_i) begin
         cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_i) begin
                  cnt_r <= '0;
                  if (b_i == '0) begin
                     rem_r   <= a_i;
                     quo_r   <= ZERO_QUOT;
                     neg_q_r <= 1'b0;
                     neg_r_r <= 1'b0;
                  end else begin
                     rem_r     <= '0;
                     quo_r     <= mag(a_i, signed_i);
                     divisor_r <= mag(b_i, signed_i);
                     neg_q_r   <= signed_i & (a_i[DATA_W-1] ^ b_i[DATA_W-1]);
                     neg_r_r   <= signed_i & a_i[DATA_W-1];
                  end
               end
            end
            ST_RUN: begin
               cnt_r <= cnt_r + CNT_W'(1);
               if (!trial_s[DATA_W]) begin
                  rem_r <= trial_s[DATA_W-1:0];
                  quo_r <= {quo_r[DATA_W-2:0], 1'b1};
               end else begin
                  rem_r <= shifted_s[DATA_W-1:0];
                  quo_r <= {quo_r[DATA_W-2:0], 1'b0};
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Outputs: stall in every busy cycle including the request cycle, result
   // and write strobe only in DONE; reset and annul silence everything.
   always_comb begin
      stall_s  = 1'b0;
      ready_s  = 1'b0;
      result_s = '0;
      if (rst || annul_i) begin
         stall_s  = 1'b0;
         ready_s  = 1'b0;
         result_s = '0;
      end else begin
         stall_s = start_i & (state_r != ST_DONE);
         if (state_r == ST_DONE) begin
            ready_s  = 1'b1;
            result_s = {neg_if(rem_r, neg_r_r), neg_if(quo_r, neg_q_r)};
         end else begin
            ready_s  = 1'b0;
            result_s = '0;
         end
      end
   end

   assign stall_o   = stall_s;
   assign ready_o   = ready_s;
   assign hilo_we_o = ready_s;
   assign result_o  = result_s;

endmodule
